// File: rtl/priority_encoder_pkg.sv
`default_nettype none
//==============================================================================
// Module      : priority_encoder_pkg
// Description : Shared widths, the no-hit code, the result layout and a 4-bit
//               highest-set-bit helper for the 16-bit priority encoder tile.
//               The package has no ports.
// Revision    : 1.0 - initial release
//==============================================================================
package priority_encoder_pkg;

  // Operand width. It is fixed by the tile pin map: ui_in (8) + uio_in (8).
  localparam int WIDTH = 16;

  // Width of the encoded bit index.
  localparam int IDX_W = 4;

  // Output code when no operand bit is set. The upper nibble is nonzero, so
  // it can never be confused with a hit result, which always has 4'b0000
  // there.
  localparam logic [7:0] NO_HIT = 8'hF0;

  // Layout of the registered result on uo_out.
  typedef struct packed {
    logic [7-IDX_W:0] pad;    // always zero on a hit
    logic [IDX_W-1:0] index;  // position of the most-significant set bit
  } result_t;

  // Returns the index of the highest set bit of a 4-bit vector.
  // An all-zero input returns 0. Callers must qualify the result with their
  // own "any bit set" flag.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[3])      r = 2'd3;
    else if (v[2]) r = 2'd2;
    else if (v[1]) r = 2'd1;
    else           r = 2'd0;
    return r;
  endfunction

endpackage : priority_encoder_pkg
`default_nettype wire

// File: rtl/priority_encoder_if.sv
`default_nettype none
//==============================================================================
// Module      : priority_encoder_if
// Description : Tiny Tapeout user-tile pin bundle for the priority encoder.
//               The master side (the tile harness or a testbench) drives the
//               enable and operand pins. The slave side (the encoder) drives
//               the dedicated outputs and the bidirectional output/enable
//               pins.
//   ena      : tile enable (master -> slave)
//   ui_in    : operand bits 15:8 (master -> slave)
//   uio_in   : operand bits 7:0 (master -> slave)
//   uo_out   : registered result (slave -> master)
//   uio_out  : bidirectional output values, always 0 (slave -> master)
//   uio_oe   : bidirectional output enables, always 0 (slave -> master)
// Revision    : 1.0 - initial release
//==============================================================================
interface priority_encoder_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface : priority_encoder_if
`default_nettype wire

// File: rtl/priority_encoder_prio_enc16.sv
`default_nettype none
//==============================================================================
// Module      : prio_enc16
// Description : Combinational 16-bit highest-set-bit encoder. It is built as a
//               two-level tree of 4-bit encoders. The first level picks the
//               highest non-empty nibble. The second level picks the highest
//               set bit inside that nibble. This keeps the logic depth at two
//               small encoders plus a 4:1 nibble mux, instead of one 16-deep
//               priority chain.
//   in   : operand, bit 15 has the highest priority
//   idx  : index of the most-significant set bit (0 when hit is low)
//   hit  : high when any operand bit is set
// Revision    : 1.0 - initial release
//==============================================================================
module prio_enc16
  import priority_encoder_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  localparam int GROUPS = WIDTH / 4;

  logic [GROUPS-1:0] group_any;  // per-nibble "some bit set"
  logic [1:0]        grp_sel;    // highest non-empty nibble
  logic [3:0]        grp_bits;   // contents of the selected nibble
  logic [1:0]        bit_sel;    // highest set bit inside that nibble

  generate
    for (genvar g = 0; g < GROUPS; g++) begin : g_group
      assign group_any[g] = |in[4*g +: 4];
    end
  endgenerate

  always_comb begin
    grp_sel  = enc4(group_any);
    // {grp_sel, 2'b00} is grp_sel*4 without losing the carry out of 2 bits.
    grp_bits = in[{grp_sel, 2'b00} +: 4];
    bit_sel  = enc4(grp_bits);
    idx      = {grp_sel, bit_sel};
    hit      = |group_any;
  end

endmodule : prio_enc16
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
//==============================================================================
// Module      : priority_encoder
// Description : Tiny Tapeout user tile. It registers the index of the
//               most-significant set bit of {ui_in, uio_in} onto uo_out. When
//               the operand is zero, it registers NO_HIT instead. The register
//               loads on each rising clk edge with ena high and holds while ena
//               is low. rst clears it to NO_HIT asynchronously. The uio pins
//               are inputs only, so uio_out and uio_oe are tied to zero.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : tile pins (ena, ui_in, uio_in, uo_out, uio_out, uio_oe)
// Revision    : 1.0 - initial release
//==============================================================================
module priority_encoder #(
  // Must stay 16: the operand is exactly {ui_in, uio_in}.
  parameter int         WIDTH  = priority_encoder_pkg::WIDTH,
  parameter logic [7:0] NO_HIT = priority_encoder_pkg::NO_HIT
) (
  input  logic                     clk,
  input  logic                     rst,
  priority_encoder_if.slave        bus
);

  import priority_encoder_pkg::*;

  logic [WIDTH-1:0] operand;
  logic [IDX_W-1:0] idx;
  logic             hit;
  result_t          next_result;
  result_t          result_q;

  assign operand = {bus.ui_in, bus.uio_in};

  prio_enc16 u_enc (
    .in  (operand),
    .idx (idx),
    .hit (hit)
  );

  // A hit always has a zero upper nibble. This keeps "bit 0 set" (0x00)
  // distinct from "no bit set" (NO_HIT).
  always_comb begin
    next_result = result_t'(NO_HIT);
    if (hit) begin
      next_result.pad   = '0;
      next_result.index = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= result_t'(NO_HIT);
    end else if (bus.ena) begin
      result_q <= next_result;
    end
  end

  assign bus.uo_out  = result_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule : priority_encoder
`default_nettype wire

// File: tb/tb_priority_encoder.sv
`default_nettype none
//==============================================================================
// Module      : tb_priority_encoder
// Description : Self-checking bench for priority_encoder. It uses directed
//               vector tables, bit walks, hand-written reset sequences and
//               randomized operands checked against a reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_priority_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   clk_run = 1'b0;

  int checks = 0;
  int errors = 0;

  priority_encoder_if bus ();

  priority_encoder #(
    .WIDTH  (16),
    .NO_HIT (8'hF0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock toggles only while clk_run is set, so reset can be tested with the
  // clock stopped.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic       ena;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] expect_out;
  } vec_t;

  // Reference: floor(log2(operand)) for a nonzero operand, else 0xF0.
  function automatic logic [7:0] ref_model(input int unsigned op);
    int unsigned v;
    int          n;
    if (op == 0) return 8'hF0;
    v = op;
    n = 0;
    while (v > 1) begin
      v = v / 2;
      n = n + 1;
    end
    return 8'(n);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [15:0] op);
    bus.ena    = e;
    bus.ui_in  = op[15:8];
    bus.uio_in = op[7:0];
  endtask

  vec_t        vecs [$];
  logic [7:0]  model_q;
  logic [15:0] op;
  logic [15:0] mask;
  logic        e;

  initial begin
    // Directed vectors: each one is applied and then checked after one edge.
    vecs.push_back('{1'b1, 8'h00, 8'h01, 8'h00});
    vecs.push_back('{1'b1, 8'h00, 8'h00, 8'hF0});
    vecs.push_back('{1'b1, 8'h05, 8'hFF, 8'h0A});
    vecs.push_back('{1'b1, 8'h00, 8'h90, 8'h07});
    vecs.push_back('{1'b1, 8'hFF, 8'hFF, 8'h0F});
    vecs.push_back('{1'b1, 8'h05, 8'hFF, 8'h0A});
    vecs.push_back('{1'b0, 8'h00, 8'h01, 8'h0A});
    vecs.push_back('{1'b0, 8'h00, 8'h01, 8'h0A});
    vecs.push_back('{1'b0, 8'h00, 8'h01, 8'h0A});
    vecs.push_back('{1'b1, 8'h00, 8'h01, 8'h00});
    vecs.push_back('{1'b1, 8'h80, 8'h00, 8'h0F});

    // Reset with the clock stopped.
    drive(1'b0, 16'h0000);
    rst = 1'b1;
    #3;
    check("reset_uo_out", bus.uo_out, 8'hF0);
    check("reset_uio_out", bus.uio_out, 8'h00);
    check("reset_uio_oe", bus.uio_oe, 8'h00);
    rst = 1'b0;
    drive(1'b1, 16'h8000);
    #2;
    clk_run = 1'b1;
    step();
    check("first_edge_bit15", bus.uo_out, 8'h0F);

    // Directed table.
    foreach (vecs[i]) begin
      drive(vecs[i].ena, {vecs[i].ui, vecs[i].uio});
      step();
      check($sformatf("vec%0d", i), bus.uo_out, vecs[i].expect_out);
    end

    // Single one walked across every position, then a one with all lower bits set.
    for (int p = 0; p < 16; p++) begin
      drive(1'b1, 16'(32'd1 << p));
      step();
      check($sformatf("walk1_%0d", p), bus.uo_out, 8'(p));
      drive(1'b1, 16'((32'd2 << p) - 1));
      step();
      check($sformatf("walkfill_%0d", p), bus.uo_out, 8'(p));
    end

    // Asynchronous reset between edges while the output holds 0x07.
    drive(1'b1, 16'h0090);
    step();
    check("pre_reset", bus.uo_out, 8'h07);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_now", bus.uo_out, 8'hF0);
    step();
    check("reset_held", bus.uo_out, 8'hF0);
    #2;
    rst = 1'b0;
    drive(1'b1, 16'h0400);
    #1;
    check("released_before_edge", bus.uo_out, 8'hF0);
    step();
    check("post_reset_load", bus.uo_out, 8'h0A);

    // Randomized operands with a random enable, checked against the model.
    model_q = 8'h0A;
    for (int n = 0; n < 400; n++) begin
      e    = ($urandom_range(0, 3) != 0);
      mask = 16'(32'hFFFF >> $urandom_range(0, 16));
      op   = 16'($urandom) & mask;
      drive(e, op);
      if (e) model_q = ref_model(32'(op));
      step();
      check("random", bus.uo_out, model_q);
      if (n % 50 == 0) begin
        check("random_uio_out", bus.uio_out, 8'h00);
        check("random_uio_oe", bus.uio_oe, 8'h00);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_priority_encoder
`default_nettype wire
